// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_bank_pkg
// Purpose : Shared types and helpers for the register-bank command sequencer
//           and the register_bank storage block.
//           - rb_op_e         : command opcodes on the request channel
//           - rb_ctrl_state_e : sequencer FSM states
//           - rb_addr_width() : address width for a given DEPTH (minimum 1)
// Revision: 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SET   = 2'd2,
    OP_CLEAR = 2'd3
  } rb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } rb_ctrl_state_e;

  // A single-register bank still needs one address bit on the wire.
  function automatic int rb_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module  : register_bank
// Purpose : DEPTH x WIDTH register storage with a combinational read port and
//           a synchronous write port.
// Ports   : clk       - clock, rising edge
//           reset_n   - asynchronous active-low reset, clears all registers
//           addr      - register address (read and write)
//           write_en  - write strobe, sampled on the rising edge
//           data_in   - write data
//           data_out  - contents of register addr, same cycle (0 if out of
//                       range)
// Revision: 1.0 - initial release
// ============================================================================
module register_bank
  import reg_bank_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = rb_addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [AW-1:0]    addr,
  input  logic             write_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_in_range;

  // Non-power-of-two depths leave unused address codes; those read as zero
  // and are never written.
  assign w_in_range = ({1'b0, addr} < c_depth);
  assign data_out   = w_in_range ? r_mem[addr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (write_en && w_in_range) begin
      r_mem[addr] <= data_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_bank_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : reg_bank_cmd_ctrl
// Purpose : Command sequencer in front of register_bank. Accepts READ, WRITE,
//           SET and CLEAR commands, performs each in a single bank cycle
//           (read-modify-write included) and returns one response per command.
// Ports   : clk, reset_n          - clock / asynchronous active-low reset
//           cmd_valid/cmd_ready   - request handshake
//           cmd_op/addr/wdata     - opcode, register address, data or mask
//           resp_valid/resp_ready - response handshake
//           resp_data/resp_err    - response payload / out-of-range flag
//           rb_addr, rb_write_en,
//           rb_data_in            - drive the bank's addr/write_en/data_in
//           rb_data_out           - bank's combinational data_out
// Revision: 1.0 - initial release
// ============================================================================
module reg_bank_cmd_ctrl
  import reg_bank_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = rb_addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic [AW-1:0]    rb_addr,
  output logic             rb_write_en,
  output logic [WIDTH-1:0] rb_data_in,
  input  logic [WIDTH-1:0] rb_data_out
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  rb_ctrl_state_e   r_state;
  rb_ctrl_state_e   w_state_nxt;
  rb_op_e           r_op;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_resp_data;
  logic [WIDTH-1:0] w_resp_data_nxt;
  logic             r_resp_err;
  logic             w_resp_err_nxt;
  logic             w_accept;
  logic             w_in_range;

  assign w_in_range = ({1'b0, r_addr} < c_depth);
  assign w_accept   = cmd_valid && cmd_ready;

  assign rb_addr    = r_addr;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

  // --------------------------------------------------------------------------
  // State and datapath registers. The bank strobe is decoded from r_state, so
  // an asynchronous reset during EXEC drops rb_write_en immediately and
  // discards any pending response.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_READ;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_resp_data <= w_resp_data_nxt;
      r_resp_err  <= w_resp_err_nxt;
      if (w_accept) begin
        r_op    <= rb_op_e'(cmd_op);
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state, handshakes and bank drive.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_resp_data_nxt = r_resp_data;
    w_resp_err_nxt  = r_resp_err;
    cmd_ready       = 1'b0;
    resp_valid      = 1'b0;
    rb_write_en     = 1'b0;
    rb_data_in      = '0;

    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        w_state_nxt = ST_RESP;
        if (!w_in_range) begin
          w_resp_data_nxt = '0;
          w_resp_err_nxt  = 1'b1;
        end else begin
          w_resp_err_nxt = 1'b0;
          case (r_op)
            OP_READ: begin
              w_resp_data_nxt = rb_data_out;
            end
            OP_WRITE: begin
              rb_write_en     = 1'b1;
              rb_data_in      = r_wdata;
              w_resp_data_nxt = r_wdata;
            end
            OP_SET: begin
              rb_write_en     = 1'b1;
              rb_data_in      = rb_data_out | r_wdata;
              w_resp_data_nxt = rb_data_out;
            end
            OP_CLEAR: begin
              rb_write_en     = 1'b1;
              rb_data_in      = rb_data_out & ~r_wdata;
              w_resp_data_nxt = rb_data_out;
            end
            default: begin
              w_resp_data_nxt = rb_data_out;
            end
          endcase
        end
      end

      ST_RESP: begin
        resp_valid = 1'b1;
        // Accepting on the same edge as the response handshake keeps the
        // pipeline at one command every two cycles.
        cmd_ready  = resp_ready;
        if (resp_ready) begin
          w_state_nxt = cmd_valid ? ST_EXEC : ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_bank_cmd_ctrl
// Purpose : Self-checking bench for reg_bank_cmd_ctrl paired with
//           register_bank (DEPTH=3 so one address code is out of range).
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_bank_cmd_ctrl;
  import reg_bank_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int AW    = rb_addr_width(DEPTH);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_wdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_err;
  logic [AW-1:0]    rb_addr;
  logic             rb_write_en;
  logic [WIDTH-1:0] rb_data_in;
  logic [WIDTH-1:0] rb_data_out;

  always #5 clk = ~clk;

  reg_bank_cmd_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ctrl (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .rb_addr     (rb_addr),
    .rb_write_en (rb_write_en),
    .rb_data_in  (rb_data_in),
    .rb_data_out (rb_data_out)
  );

  register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .addr     (rb_addr),
    .write_en (rb_write_en),
    .data_in  (rb_data_in),
    .data_out (rb_data_out)
  );

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               wr_pulses = 0;
  int               last_resp_cyc = -1;
  logic [WIDTH:0]   sb_q [$];
  logic [WIDTH-1:0] mdl [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rb_write_en) wr_pulses <= wr_pulses + 1;
  end

  // Response monitor / scoreboard
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (reset_n && resp_valid && resp_ready) begin
      check("resp_expected", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("resp_data", resp_data, e[WIDTH-1:0]);
        check("resp_err", resp_err, e[WIDTH]);
      end
      last_resp_cyc <= cyc;
    end
  end

  // Drive one command; returns the cycle stamp of its accept edge.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] a,
                      input logic [WIDTH-1:0] d, input bit expect_resp,
                      output int acc_cyc);
    logic [WIDTH-1:0] exp_d;
    logic             exp_e;
    bit               done;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    done      = 1'b0;
    acc_cyc   = -1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
        exp_e   = (int'(a) >= DEPTH);
        exp_d   = '0;
        if (!exp_e) begin
          case (op)
            2'd0: exp_d = mdl[a];
            2'd1: begin exp_d = d; mdl[a] = d; end
            2'd2: begin exp_d = mdl[a]; mdl[a] = mdl[a] | d; end
            default: begin exp_d = mdl[a]; mdl[a] = mdl[a] & ~d; end
          endcase
        end
        if (expect_resp) sb_q.push_back({exp_e, exp_d});
      end
    end
    check("cmd_accepted", done, 1);
    @(posedge clk);
    #1;
    // Garbage on the idle request bus must be ignored.
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_addr  = AW'($urandom_range(0, 3));
    cmd_wdata = WIDTH'($urandom_range(0, 255));
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int prev;
    int w0;
    logic [WIDTH-1:0] v;

    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'd0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_rb_addr", rb_addr, 0);
    check("rst_rb_write_en", rb_write_en, 0);
    check("rst_rb_data_in", rb_data_in, 0);
    @(posedge clk);
    #1;

    // Single write / read, untouched register
    send(OP_WRITE, 2'd2, 8'hA5, 1, acc);
    send(OP_READ,  2'd2, 8'h00, 1, acc);
    send(OP_READ,  2'd1, 8'h00, 1, acc);
    drain();

    // Read-modify-write: 0x0F, 0x0F, 0x3F, 0x3A
    send(OP_WRITE, 2'd0, 8'h0F, 1, acc);
    send(OP_SET,   2'd0, 8'h30, 1, acc);
    send(OP_CLEAR, 2'd0, 8'h05, 1, acc);
    send(OP_READ,  2'd0, 8'h00, 1, acc);
    drain();

    // Back-pressure
    resp_ready = 1'b0;
    w0 = wr_pulses;
    send(OP_WRITE, 2'd1, 8'h3C, 1, acc);
    cmd_valid = 1'b1;
    cmd_op    = OP_READ;
    cmd_addr  = 2'd1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_valid", resp_valid, 1);
      check("bp_resp_data", resp_data, 8'h3C);
      check("bp_cmd_ready", cmd_ready, 0);
    end
    @(posedge clk);
    #1;
    check("bp_write_pulses", wr_pulses - w0, 1);
    resp_ready = 1'b1;
    send(OP_READ, 2'd1, 8'h00, 1, acc);
    check("bp_accept_on_handshake", acc, last_resp_cyc);
    drain();

    // Streaming WRITE/READ pairs
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      v = WIDTH'($urandom_range(0, 255));
      send(OP_WRITE, AW'(i % DEPTH), v, 1, acc);
      if (prev >= 0) check("stream_gap", acc - prev, 2);
      prev = acc;
      send(OP_READ, AW'(i % DEPTH), 8'h00, 1, acc);
      check("stream_gap", acc - prev, 2);
      prev = acc;
    end
    drain();

    // Out-of-range address
    w0 = wr_pulses;
    send(OP_WRITE, 2'd3, 8'hFF, 1, acc);
    send(OP_SET,   2'd3, 8'hFF, 1, acc);
    drain();
    check("oor_no_write", wr_pulses - w0, 0);
    for (int i = 0; i < DEPTH; i++) send(OP_READ, AW'(i), 8'h00, 1, acc);
    drain();

    // Reset during EXEC of a write
    send(OP_WRITE, 2'd1, 8'h55, 0, acc);
    check("exec_write_en", rb_write_en, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_exec_write_en", rb_write_en, 0);
    check("rst_exec_resp_valid", resp_valid, 0);
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_resp_valid", resp_valid, 0);
    @(posedge clk);
    #1;
    send(OP_READ, 2'd1, 8'h00, 1, acc);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_bank_cmd_ctrl.md
# reg_bank_cmd_ctrl

Command sequencer sitting directly upstream of the `register_bank` storage block. It accepts read, write, bit-set and bit-clear commands on a valid/ready request channel and drives the bank's `addr`/`write_en`/`data_in` pins. It samples the bank's combinational `data_out` and returns one response per command on a valid/ready response channel. Read-modify-write ops execute atomically in one bank cycle.

## Interface
Parameters:
- `WIDTH`, default 8: data width; must match the bank.
- `DEPTH`, default 4: number of bank registers; `AW = $clog2(DEPTH)`, minimum 1.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  operation: 0 READ, 1 WRITE, 2 SET (`reg |= wdata`), 3 CLEAR (`reg &= ~wdata`).
- `cmd_addr`  in  AW  target register.
- `cmd_wdata`  in  WIDTH  write data or bit mask.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_data`  out  WIDTH  READ: register value. WRITE: value written. SET/CLEAR: value before modification.
- `resp_err`  out  1  `cmd_addr >= DEPTH`; no write performed.
- `rb_addr`  out  AW  to bank `addr`.
- `rb_write_en`  out  1  to bank `write_en`.
- `rb_data_in`  out  WIDTH  to bank `data_in`.
- `rb_data_out`  in  WIDTH  from bank `data_out`; combinational, same-cycle.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE:** `cmd_ready=1`. On `cmd_valid && cmd_ready`, latch op, addr and wdata, then go to EXEC.
- **EXEC** (exactly one cycle): `rb_addr` = latched addr.
  - READ: capture `rb_data_out` into `resp_data`.
  - WRITE: `rb_write_en=1`, `rb_data_in=wdata`, `resp_data=wdata`.
  - SET/CLEAR: `rb_data_in = rb_data_out | wdata` (SET) or `rb_data_out & ~wdata` (CLEAR), `rb_write_en=1`, `resp_data = rb_data_out`.
  - Out-of-range address: `rb_write_en=0`, `resp_data=0`, `resp_err=1`.
  - Then go to RESP.
- **RESP:** `resp_valid=1`. `resp_data` and `resp_err` are held stable until `resp_valid && resp_ready`.
  - On the handshake with `cmd_valid=0`: go to IDLE.
  - On the handshake with `cmd_valid=1`: `cmd_ready=1` this cycle (combinational from `resp_ready`), accept the new command and go straight to EXEC.
- `cmd_ready=0` in EXEC, and in RESP whenever `resp_ready=0`.
- `rb_write_en` is asserted only in EXEC and only for in-range WRITE/SET/CLEAR.
- `rb_addr` holds the last latched address outside EXEC.
- `rb_data_in` = 0 outside EXEC.
- Exactly one response per accepted command, in order. No command is ever dropped or duplicated.

## Timing
- Reset values: state IDLE; `cmd_ready=1` (once `reset_n` is high); `resp_valid=0`; `resp_data=0`; `resp_err=0`; `rb_addr=0`; `rb_write_en=0`; `rb_data_in=0`.
- Latency: command accepted at edge N, bank write occurs at edge N+1, `resp_valid` is high in the cycle after edge N+1.
- Throughput: one command per 2 cycles when `resp_ready` and `cmd_valid` are held high.
- Back-pressure: `resp_ready=0` stalls indefinitely in RESP with all outputs stable.
- Back-to-back commands to the same address: the second command observes the first's write, because the bank has updated before the second EXEC.
- Reset asserted mid-EXEC: the write is suppressed as soon as `reset_n` falls (`rb_write_en` is forced 0 asynchronously). Any pending response is discarded.
- Inputs `cmd_*` are sampled only on the accept edge; changes at other times are ignored.

## Structure
- Package `reg_bank_pkg`:
  - `typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_SET, OP_CLEAR} rb_op_e;`
  - FSM state enum `rb_ctrl_state_e`.
- No sub-module inside this block.
- The top level instantiates `reg_bank_cmd_ctrl` and `register_bank` side by side with matching `WIDTH`/`DEPTH`.
- The bench exercises the pair together.

## Test plan
- **Reset, then single write/read:** after reset, WRITE addr 2 data 0xA5, then READ addr 2 → responses 0xA5 and 0xA5, `resp_err=0`. Read of untouched addr 1 returns 0x00.
- **Read-modify-write:** WRITE addr 0 0x0F, SET addr 0 0x30, CLEAR addr 0 0x05, READ addr 0 → responses 0x0F, 0x0F, 0x3F, 0x3A.
- **Back-pressure:** hold `resp_ready=0` for 5 cycles after the first command → `resp_valid`/`resp_data` stable, `cmd_ready=0`, `rb_write_en` pulses exactly once. Release → the next command is accepted in the same cycle as the handshake.
- **Streaming:** 8 back-to-back WRITE/READ pairs with `resp_ready=1` → one response every 2 cycles, in order, values correct.
- **Out-of-range:** with `DEPTH=3`, WRITE addr 3 0xFF → `resp_err=1`, `resp_data=0`, no `rb_write_en`. Subsequent reads of addrs 0–2 are unchanged.
- **Reset mid-operation:** assert `reset_n=0` during EXEC of WRITE addr 1 0x55 → no bank write, `resp_valid=0`. After release, READ addr 1 returns 0x00.
